// File: rtl/bm_output_receiver.sv
// Consumer side of a BondMachine output port: four-phase capture of each published word
// into a first-word-fall-through FIFO, with a last-value register and a capture counter.
module bm_output_receiver #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] o,
    input  logic             o_valid,
    output logic             o_received,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] last_value,
    output logic [15:0]      capture_count,
    output logic [AW:0]      level
);

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_last_value;
    logic [15:0]      r_capture_count;

    assign w_pop = (r_level != '0) && dout_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Full is judged on the current level; a same-edge pop does not free a slot.
                if (o_valid && (r_level != FULL_LEVEL)) begin
                    w_push       = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!o_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_last_value    <= '0;
            r_capture_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + AW'(1);
                r_last_value    <= o;
                r_capture_count <= r_capture_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= o;
        end
    end

    assign o_received    = (r_state == ST_ACK);
    assign dout          = r_mem[r_rd_ptr];
    assign dout_valid    = (r_level != '0);
    assign last_value    = r_last_value;
    assign capture_count = r_capture_count;
    assign level         = r_level;

endmodule

// File: tb/tb_bm_output_receiver.sv
// Directed bench for bm_output_receiver: a queue-based model checked every cycle,
// plus hand-computed expectations for each test scenario.
module tb_bm_output_receiver;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             o_received;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [WIDTH-1:0] last_value;
    logic [15:0]      capture_count;
    logic [AW:0]      level;

    bm_output_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .o             (o),
        .o_valid       (o_valid),
        .o_received    (o_received),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .last_value    (last_value),
        .capture_count (capture_count),
        .level         (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word queue, a "this valid period already captured" flag, last word, count.
    logic [WIDTH-1:0] m_q[$];
    bit               m_taken;
    logic [WIDTH-1:0] m_last;
    logic [15:0]      m_count;
    logic [WIDTH-1:0] dut_log[$];

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_taken = 1'b0;
            m_last  = '0;
            m_count = '0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (m_q.size() != 0) && dout_ready;
            do_push = !m_taken && o_valid && (m_q.size() < DEPTH);
            if (m_taken && !o_valid) m_taken = 1'b0;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(o);
                m_last  = o;
                m_count = m_count + 16'd1;
                m_taken = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_received", 32'(o_received), 32'(m_taken));
            check("cyc_level", 32'(level), m_q.size());
            check("cyc_dout_valid", 32'(dout_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("cyc_dout", 32'(dout), 32'(m_q[0]));
            check("cyc_last_value", 32'(last_value), 32'(m_last));
            check("cyc_capture_count", 32'(capture_count), 32'(m_count));
            if (dout_valid && dout_ready) dut_log.push_back(dout);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        o_valid    = 1'b0;
        dout_ready = 1'b0;
        o          = '0;
        tick(1);
        reset = 1'b0;
        dut_log.delete();
        chk_en = 1'b1;
    endtask

    task automatic pulse(input logic [WIDTH-1:0] w);
        o       = w;
        o_valid = 1'b1;
        tick(1);
        o_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        reset      = 1'b1;
        o          = '0;
        o_valid    = 1'b0;
        dout_ready = 1'b0;
        tick(2);

        // Reset state
        do_reset();
        check("rst_received", 32'(o_received), 0);
        check("rst_level", 32'(level), 0);
        check("rst_dout_valid", 32'(dout_valid), 0);
        check("rst_count", 32'(capture_count), 0);

        // 1. Single transfer held for three cycles
        o       = 16'h0005;
        o_valid = 1'b1;
        tick(1);
        check("t1_ack_rise", 32'(o_received), 1);
        tick(2);
        check("t1_ack_held", 32'(o_received), 1);
        o_valid = 1'b0;
        tick(1);
        check("t1_ack_fall", 32'(o_received), 0);
        check("t1_level", 32'(level), 1);
        check("t1_dout", 32'(dout), 32'h5);
        check("t1_last", 32'(last_value), 32'h5);
        check("t1_count", 32'(capture_count), 1);

        // 2. Valid held high while data changes: only the first word is taken
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            o       = 16'(i);
            o_valid = 1'b1;
            tick(1);
        end
        check("t2_count_held", 32'(capture_count), 1);
        check("t2_level_held", 32'(level), 1);
        o_valid = 1'b0;
        tick(1);
        o       = 16'h00AA;
        o_valid = 1'b1;
        tick(1);
        o_valid = 1'b0;
        tick(1);
        check("t2_count", 32'(capture_count), 2);
        dout_ready = 1'b1;
        tick(2);
        dout_ready = 1'b0;
        check("t2_npop", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("t2_pop0", 32'(dut_log[0]), 32'h1);
            check("t2_pop1", 32'(dut_log[1]), 32'hAA);
        end

        // 3. Backpressure at full
        do_reset();
        for (int i = 0; i < 4; i++) pulse(16'(16'h10 + i));
        check("t3_full", 32'(level), 4);
        o       = 16'h0014;
        o_valid = 1'b1;
        tick(3);
        check("t3_no_ack", 32'(o_received), 0);
        check("t3_count4", 32'(capture_count), 4);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        check("t3_no_ack_on_pop", 32'(o_received), 0);
        check("t3_level3", 32'(level), 3);
        tick(1);
        check("t3_late_ack", 32'(o_received), 1);
        check("t3_level4", 32'(level), 4);
        o_valid = 1'b0;
        tick(1);
        dout_ready = 1'b1;
        tick(4);
        dout_ready = 1'b0;
        check("t3_npop", dut_log.size(), 5);
        if (dut_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t3_order", 32'(dut_log[i]), 32'h10 + i);
        end

        // 4. Simultaneous push and pop at level 2
        do_reset();
        pulse(16'h00A1);
        pulse(16'h00A2);
        check("t4_level_pre", 32'(level), 2);
        o          = 16'h00A3;
        o_valid    = 1'b1;
        dout_ready = 1'b1;
        tick(1);
        o_valid    = 1'b0;
        dout_ready = 1'b0;
        check("t4_level_same", 32'(level), 2);
        check("t4_head", 32'(dout), 32'hA2);
        tick(1);
        dout_ready = 1'b1;
        tick(2);
        dout_ready = 1'b0;
        check("t4_npop", dut_log.size(), 3);
        if (dut_log.size() == 3) begin
            check("t4_pop0", 32'(dut_log[0]), 32'hA1);
            check("t4_pop1", 32'(dut_log[1]), 32'hA2);
            check("t4_pop2", 32'(dut_log[2]), 32'hA3);
        end

        // 5. Streaming with wrap-around
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            o       = 16'(i);
            o_valid = 1'b1;
            tick(1);
            check("t5_level_le1", 32'(level <= 1), 1);
            o_valid = 1'b0;
            tick(1);
            check("t5_level_le1", 32'(level <= 1), 1);
        end
        tick(1);
        dout_ready = 1'b0;
        check("t5_count", 32'(capture_count), 20);
        check("t5_npop", dut_log.size(), 20);
        if (dut_log.size() == 20) begin
            for (int i = 0; i < 20; i++) check("t5_order", 32'(dut_log[i]), i);
        end

        // 6. Reset while acknowledging with three words buffered
        do_reset();
        pulse(16'h00B1);
        pulse(16'h00B2);
        o       = 16'h00B3;
        o_valid = 1'b1;
        tick(1);
        check("t6_pre_ack", 32'(o_received), 1);
        check("t6_pre_level", 32'(level), 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_received", 32'(o_received), 0);
        check("t6_level", 32'(level), 0);
        check("t6_dout_valid", 32'(dout_valid), 0);
        check("t6_last", 32'(last_value), 0);
        check("t6_count", 32'(capture_count), 0);
        o_valid = 1'b0;
        tick(1);
        o       = 16'h0077;
        o_valid = 1'b1;
        tick(1);
        check("t6_post_ack", 32'(o_received), 1);
        check("t6_post_level", 32'(level), 1);
        check("t6_post_dout", 32'(dout), 32'h77);
        check("t6_post_count", 32'(capture_count), 1);
        o_valid = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
